// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the instruction-fetch front end.
// Holds the reset-PC default, opcode constants, the fetch FSM state encoding,
// the queue entry layout and the branch-offset helper.
package fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          ENTRY_W          = 64;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Sign-extended 16-bit immediate scaled to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry synchronous FIFO of fetched {pc, instr} words.
// Ports: clk, reset (sync, active-high); push/din write an entry; pop drops
// the head; clear empties the queue and overrides push/pop; head is the
// oldest entry; count is the number of valid entries (0..2).
module fetch_queue
    import fetch_unit_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               clear,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] head,
    output logic [1:0]         count
);

    logic [ENTRY_W-1:0] e0, e1;
    logic               do_pop, do_push;

    assign do_pop  = pop && count != 2'd0;
    assign do_push = push && (count != 2'd2 || do_pop);
    assign head    = e0;

    always_ff @(posedge clk) begin
        if (reset) begin
            e0    <= '0;
            e1    <= '0;
            count <= 2'd0;
        end else if (clear) begin
            count <= 2'd0;
        end else begin
            if (do_pop)
                e0 <= (do_push && count == 2'd1) ? din : e1;
            else if (do_push && count == 2'd0)
                e0 <= din;
            // a push lands directly behind whatever survives this cycle's pop
            if (do_push && (count - {1'b0, do_pop}) == 2'd1)
                e1 <= din;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction-fetch front end; owns the PC, reads imem and
// feeds decode through a 2-entry queue, redirecting on branch/jump/jr.
// Optional feature macro: FETCH_ALIGN_CHECK_EN adds the sticky fetch_err flag.
// Ports: clk, reset (sync, active-high);
//   imem_req/imem_addr/imem_rvalid/imem_rdata - instruction memory read port;
//   if_valid/if_instr/if_pc/if_ready - decode handshake on the queue head;
//   pc_update/branch/jump/jr/rd_pc/rd_instr/jr_addr - redirect from control;
//   fetch_err - misaligned redirect target seen (feature build only).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    input  logic        pc_update,
    input  logic        branch,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] rd_pc,
    input  logic [31:0] rd_instr,
    input  logic [31:0] jr_addr
`ifdef FETCH_ALIGN_CHECK_EN
    , output logic      fetch_err
`endif
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next, req_addr, req_addr_next;
    logic [31:0]  seq_pc, tgt_raw, target;
    logic [1:0]   count, count_next;
    logic         push, pop, issue, issue_new;
    fetch_entry_t head;
    logic         unused;

    // branch is the default redirect kind, so it never has to be decoded
    assign unused = &{1'b0, branch, rd_instr[31:26], tgt_raw[1:0]};

    assign seq_pc  = rd_pc + 32'd4;
    assign tgt_raw = jr   ? jr_addr :
                     jump ? {seq_pc[31:28], rd_instr[25:0], 2'b00} :
                            seq_pc + branch_offset(rd_instr[15:0]);
    assign target  = {tgt_raw[31:2], 2'b00};

    // a redirect flushes the queue, so neither the pop nor the response counts
    assign pop        = if_valid && if_ready && !pc_update;
    assign push       = state == WAIT && imem_rvalid && !pc_update;
    assign count_next = count + {1'b0, push} - {1'b0, pop};
    assign issue      = !reset && !pc_update && count_next < 2'd2;
    // a new request starts either from IDLE or in the cycle the previous one completes
    assign issue_new  = issue && (state == IDLE || (state == WAIT && imem_rvalid));

    assign imem_req  = !reset && (issue_new || (state != IDLE && !imem_rvalid));
    assign imem_addr = issue_new ? pc : req_addr;

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        req_addr_next = req_addr;
        if (pc_update) begin
            pc_next    = target;
            state_next = (state == IDLE || imem_rvalid) ? IDLE : DROP;
        end else if (issue_new) begin
            req_addr_next = pc;
            pc_next       = pc + 32'd4;
            state_next    = WAIT;
        end else if (imem_rvalid && state != IDLE) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            req_addr <= req_addr_next;
        end
    end

    fetch_queue u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (pc_update),
        .din   ({req_addr, imem_rdata}),
        .head  (head),
        .count (count)
    );

    assign if_valid = count != 2'd0;
    assign if_pc    = head.pc;
    assign if_instr = head.instr;

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset)
            fetch_err <= 1'b0;
        else if (pc_update && tgt_raw[1:0] != 2'b00)
            fetch_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit with a latency-configurable memory and a stream reference model.
module tb_fetch_unit;

    localparam logic [31:0] RST = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        pc_update, branch, jump, jr;
    logic [31:0] rd_pc, rd_instr, jr_addr;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_err;
`endif

    int tests = 0;
    int fails = 0;

    fetch_unit #(.RESET_PC(RST)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_ready    (if_ready),
        .pc_update   (pc_update),
        .branch      (branch),
        .jump        (jump),
        .jr          (jr),
        .rd_pc       (rd_pc),
        .rd_instr    (rd_instr),
        .jr_addr     (jr_addr)
`ifdef FETCH_ALIGN_CHECK_EN
        , .fetch_err (fetch_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // redirect target straight from the architectural rules
    function automatic logic [31:0] ref_target(input logic j_r, input logic j,
                                               input logic [31:0] pc, input logic [31:0] ins,
                                               input logic [31:0] ja);
        logic [31:0] seq;
        logic [31:0] off;
        seq = pc + 32'd4;
        off = 32'($signed(ins[15:0])) * 32'd4;
        if (j_r) return ja & ~32'd3;
        if (j) return {seq[31:28], ins[25:0], 2'b00};
        return (seq + off) & ~32'd3;
    endfunction

    // instruction memory: one request at a time, latency lat_lo..lat_hi cycles
    int          lat_lo = 1, lat_hi = 1;
    logic        s_r = 1'b0, s_v = 1'b0, s_rst = 1'b1;
    logic [31:0] s_a = 32'h0;
    logic        mbusy = 1'b0;
    int          mcnt = 0;
    logic [31:0] maddr = 32'h0;

    always @(negedge clk) begin
        s_r   = imem_req;
        s_a   = imem_addr;
        s_v   = imem_rvalid;
        s_rst = reset;
    end

    always @(posedge clk) begin
        #1;
        if (s_rst) begin
            mbusy       = 1'b0;
            imem_rvalid = 1'b0;
        end else begin
            if (s_v)
                mbusy = 1'b0;
            else if (mbusy) begin
                check("req_held", 32'(s_r), 32'd1);
                check("addr_stable", s_a, maddr);
            end
            if (s_r && !mbusy) begin
                mbusy = 1'b1;
                maddr = s_a;
                mcnt  = int'($urandom_range(lat_hi, lat_lo)) - 1;
            end else if (mbusy && mcnt > 0)
                mcnt--;
            imem_rvalid = mbusy && mcnt == 0;
            imem_rdata  = imem_rvalid ? mem_word(maddr) : 32'hDEAD_BEEF;
        end
    end

    // reference model: delivery is the sequential word stream from the last reset/redirect target
    logic [31:0] exp_pc = RST;
    always @(negedge clk) begin
        if (reset)
            exp_pc = RST;
        else if (pc_update)
            exp_pc = ref_target(jr, jump, rd_pc, rd_instr, jr_addr);
        else if (if_valid && if_ready) begin
            check("model_pc", if_pc, exp_pc);
            check("model_instr", if_instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // returns at the negedge of the next accepted head, or reports a timeout
    task automatic get_hs(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (if_valid && if_ready && !pc_update) ok = 1'b1;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL %s: no delivery within 60 cycles, required one", name);
        end
    endtask

    typedef struct {
        string       name;
        logic        v_jr;
        logic        v_jump;
        logic        v_branch;
        logic [31:0] v_pc;
        logic [31:0] v_instr;
        logic [31:0] v_ja;
        logic [31:0] v_exp;
    } vec_t;

    vec_t vt[10];

    initial begin
        vt[0] = '{"br_back",   1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'h1000_FFFE, 32'h0,         32'h0000_00FC};
        vt[1] = '{"jump",      1'b0, 1'b1, 1'b0, 32'h1000_0000, 32'h0800_0040, 32'h0,         32'h1000_0100};
        vt[2] = '{"jr_top",    1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFFC};
        vt[3] = '{"jr_prio",   1'b1, 1'b1, 1'b1, 32'h0000_0800, 32'h0800_0001, 32'h0000_0400, 32'h0000_0400};
        vt[4] = '{"jump_prio", 1'b0, 1'b1, 1'b1, 32'h0000_2000, 32'h0000_0010, 32'h0,         32'h0000_0040};
        vt[5] = '{"no_kind",   1'b0, 1'b0, 1'b0, 32'h0000_0300, 32'h0000_0004, 32'h0,         32'h0000_0314};
        vt[6] = '{"br_fwd",    1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_7FFF, 32'h0,         32'h0002_0000};
        vt[7] = '{"br_wrap",   1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1000_0000, 32'h0,         32'h0000_0000};
        vt[8] = '{"jump_nib",  1'b0, 1'b1, 1'b0, 32'h0FFF_FFFC, 32'h0BFF_FFFF, 32'h0,         32'h1FFF_FFFC};
        vt[9] = '{"jr_misal",  1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0202, 32'h0000_0200};

        reset = 1'b1; if_ready = 1'b1; pc_update = 1'b0;
        branch = 1'b0; jump = 1'b0; jr = 1'b0;
        rd_pc = 32'h0; rd_instr = 32'h0; jr_addr = 32'h0;
        repeat (3) cyc();
        @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, RST);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_pc", if_pc, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        check("rst_err", 32'(fetch_err), 32'd0);
`endif

        // reset release with 1-cycle memory: back-to-back delivery from RESET_PC
        cyc(); reset = 1'b0;
        @(negedge clk);
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, RST);
        cyc();
        @(negedge clk);
        check("latency_valid", 32'(if_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            @(negedge clk);
            check("seq_valid", 32'(if_valid), 32'd1);
            check("seq_pc", if_pc, RST + 32'(4 * i));
        end

        // decode stall fills the queue and stops requests
        cyc(); if_ready = 1'b0;
        repeat (4) cyc();
        @(negedge clk);
        check("stall_no_req", 32'(imem_req), 32'd0);
        check("stall_valid", 32'(if_valid), 32'd1);
        cyc(); if_ready = 1'b1;
        repeat (4) get_hs("stall_release");

        // table of redirects, each taken from a full queue in IDLE
        foreach (vt[k]) begin
            cyc(); if_ready = 1'b0;
            repeat (5) cyc();
            @(negedge clk);
            check({vt[k].name, "_full"}, 32'(imem_req), 32'd0);
            cyc();
            if_ready = 1'b1; pc_update = 1'b1;
            jr = vt[k].v_jr; jump = vt[k].v_jump; branch = vt[k].v_branch;
            rd_pc = vt[k].v_pc; rd_instr = vt[k].v_instr; jr_addr = vt[k].v_ja;
            cyc();
            pc_update = 1'b0; jr = 1'b0; jump = 1'b0; branch = 1'b0;
            @(negedge clk);
            check({vt[k].name, "_req"}, 32'(imem_req), 32'd1);
            check({vt[k].name, "_addr"}, imem_addr, vt[k].v_exp);
            get_hs(vt[k].name);
            check({vt[k].name, "_pc0"}, if_pc, vt[k].v_exp);
            get_hs(vt[k].name);
            check({vt[k].name, "_pc1"}, if_pc, vt[k].v_exp + 32'd4);
        end

        // jump while a 3-cycle request is outstanding: stale response dropped
        lat_lo = 3; lat_hi = 3;
        repeat (6) cyc();
        for (int i = 0; i < 20 && !(mbusy && !imem_rvalid); i++) cyc();
        pc_update = 1'b1; jump = 1'b1; rd_pc = 32'h0000_0500; rd_instr = 32'h0800_0300;
        @(negedge clk);
        check("drop_req_held", 32'(imem_req), 32'd1);
        cyc(); pc_update = 1'b0; jump = 1'b0;
        get_hs("drop");
        check("drop_first_pc", if_pc, 32'h0000_0C00);
        check("drop_first_instr", if_instr, mem_word(32'h0000_0C00));

        // reset in the middle of an outstanding request
        repeat (2) cyc();
        reset = 1'b1;
        repeat (2) cyc();
        @(negedge clk);
        check("midrst_req", 32'(imem_req), 32'd0);
        cyc(); reset = 1'b0;
        @(negedge clk);
        check("midrst_req_up", 32'(imem_req), 32'd1);
        check("midrst_addr", imem_addr, RST);
        get_hs("midrst");
        check("midrst_pc", if_pc, RST);
        lat_lo = 1; lat_hi = 1;

`ifdef FETCH_ALIGN_CHECK_EN
        cyc(); reset = 1'b1;
        repeat (2) cyc(); reset = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        check("err_clear", 32'(fetch_err), 32'd0);
        cyc(); pc_update = 1'b1; jr = 1'b1; jr_addr = 32'h0000_0202;
        cyc(); pc_update = 1'b0; jr = 1'b0;
        @(negedge clk);
        check("err_set", 32'(fetch_err), 32'd1);
        get_hs("err_resume");
        check("err_resume_pc", if_pc, 32'h0000_0200);
        repeat (5) cyc();
        @(negedge clk);
        check("err_sticky", 32'(fetch_err), 32'd1);
`endif

        // randomized traffic against the stream model
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if (i % 200 == 0) lat_hi = int'($urandom_range(4, 1));
            if_ready = $urandom_range(9, 0) < 7;
            if ($urandom_range(15, 0) == 0) begin
                pc_update = 1'b1;
                jr        = $urandom_range(3, 0) == 0;
                jump      = $urandom_range(2, 0) == 0;
                branch    = $urandom_range(1, 0) == 0;
                rd_pc     = $urandom & ~32'd3;
                rd_instr  = $urandom;
                jr_addr   = $urandom;
            end else begin
                pc_update = 1'b0; jr = 1'b0; jump = 1'b0; branch = 1'b0;
            end
        end
        cyc();
        pc_update = 1'b0; jr = 1'b0; jump = 1'b0; branch = 1'b0; if_ready = 1'b1;
        get_hs("final_drain");
        repeat (10) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
